// File: rtl/d_ip_irq_ctrl.sv
// d_ip_irq_ctrl: edge-detecting interrupt aggregator behind d_ip_timer.
// Define D_IP_IRQ_SYNC_EN to add a two-flop synchronizer on each src_in bit.
module d_ip_irq_ctrl #(
    parameter int N_SRC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       addr,
    input  logic             wr_en,
    input  logic             mod_en,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata,
    input  logic [N_SRC-1:0] src_in,
    output logic             irq_out
);

    localparam logic [5:0] A_PEND   = 6'h00;
    localparam logic [5:0] A_ENABLE = 6'h01;
    localparam logic [5:0] A_RAW    = 6'h02;
    localparam logic [5:0] A_FORCE  = 6'h03;
    localparam logic [5:0] A_ID     = 6'h04;
    localparam logic [5:0] A_MISSED = 6'h05;
    localparam logic [5:0] A_CTRL   = 6'h06;

    logic [N_SRC-1:0] s;
    logic [N_SRC-1:0] s_d_q;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] en_q, en_d;
    logic [N_SRC-1:0] missed_q, missed_d;
    logic             gie_q, gie_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             irq_q, irq_d;

`ifdef D_IP_IRQ_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for asynchronous sources
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src_in;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = src_in;
`endif

    logic             wr, rd;
    logic [N_SRC-1:0] wmask, rise, masked;
    logic [2:0]       id_idx;
    logic [7:0]       id_val;

    assign wr     = mod_en & wr_en;
    assign rd     = mod_en & ~wr_en;
    assign wmask  = wdata[N_SRC-1:0];
    assign rise   = s & ~s_d_q;
    assign masked = pend_q & en_q;

    // Lowest-numbered enabled pending source for the ID register
    always_comb begin
        id_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (masked[i]) id_idx = 3'(i);
        end
        id_val = (|masked) ? {1'b1, 4'b0000, id_idx} : 8'h00;
    end

    // Next-state for the register file; set terms win over W1C
    always_comb begin
        logic [N_SRC-1:0] p_set, p_clr, m_clr;
        p_set = rise;
        p_clr = '0;
        m_clr = '0;
        en_d  = en_q;
        gie_d = gie_q;
        if (wr) begin
            unique case (addr)
                A_PEND:   p_clr = wmask;
                A_ENABLE: en_d  = wmask;
                A_FORCE:  p_set = rise | wmask;
                A_MISSED: m_clr = wmask;
                A_CTRL:   gie_d = wdata[0];
                default:  ;
            endcase
        end
        pend_d   = p_set | (pend_q & ~p_clr);
        missed_d = (rise & pend_q) | (missed_q & ~m_clr);
        irq_d    = gie_q & (|masked);
    end

    // Read mux; rdata only reloads on a read access
    always_comb begin
        rdata_d = rdata_q;
        if (rd) begin
            unique case (addr)
                A_PEND:   rdata_d = 8'(pend_q);
                A_ENABLE: rdata_d = 8'(en_q);
                A_RAW:    rdata_d = 8'(s);
                A_ID:     rdata_d = id_val;
                A_MISSED: rdata_d = 8'(missed_q);
                A_CTRL:   rdata_d = {7'b0, gie_q};
                default:  rdata_d = 8'h00;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_d_q    <= '0;
            pend_q   <= '0;
            en_q     <= '0;
            missed_q <= '0;
            gie_q    <= 1'b0;
            rdata_q  <= 8'h00;
            irq_q    <= 1'b0;
        end else begin
            s_d_q    <= s;
            pend_q   <= pend_d;
            en_q     <= en_d;
            missed_q <= missed_d;
            gie_q    <= gie_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign rdata   = rdata_q;
    assign irq_out = irq_q;

endmodule

// File: tb/tb_d_ip_irq_ctrl.sv
// tb_d_ip_irq_ctrl: directed and random checks of d_ip_irq_ctrl
// against a bit-level reference model of the register behaviour.
module tb_d_ip_irq_ctrl;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] addr = '0;
    logic       wr_en = 1'b0;
    logic       mod_en = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic [2:0] src_in = '0;
    logic       irq_out;

    int n_vec = 0;
    int n_err = 0;

    bit       m_pend[N], m_en[N], m_missed[N], m_sd[N];
    bit       m_sh1[N], m_sh2[N];
    bit       m_gie, m_irq;
    bit [7:0] m_rdata;

    d_ip_irq_ctrl #(.N_SRC(N)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en),
        .mod_en(mod_en), .wdata(wdata), .rdata(rdata),
        .src_in(src_in), .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0; m_en[i] = 0; m_missed[i] = 0;
            m_sd[i] = 0; m_sh1[i] = 0; m_sh2[i] = 0;
        end
        m_gie = 0; m_irq = 0; m_rdata = 8'h00;
    endtask

    function automatic bit any_active();
        for (int i = 0; i < N; i++)
            if (m_pend[i] && m_en[i]) return 1;
        return 0;
    endfunction

    task automatic model_edge(input logic [2:0] src, input bit me,
                              input bit we, input logic [5:0] a,
                              input logic [7:0] wd);
        bit s[N];
        bit w;
        bit [7:0] rv;
        for (int i = 0; i < N; i++) begin
`ifdef D_IP_IRQ_SYNC_EN
            s[i] = m_sh2[i];
`else
            s[i] = src[i];
`endif
        end
        if (me && !we) begin
            rv = 8'h00;
            case (a)
                6'd0: for (int i = 0; i < N; i++) rv[i] = m_pend[i];
                6'd1: for (int i = 0; i < N; i++) rv[i] = m_en[i];
                6'd2: for (int i = 0; i < N; i++) rv[i] = s[i];
                6'd4: begin
                    for (int i = N - 1; i >= 0; i--)
                        if (m_pend[i] && m_en[i]) rv = 8'h80 + 8'(i);
                end
                6'd5: for (int i = 0; i < N; i++) rv[i] = m_missed[i];
                6'd6: rv[0] = m_gie;
                default: rv = 8'h00;
            endcase
            m_rdata = rv;
        end
        m_irq = m_gie && any_active();
        w = me && we;
        for (int i = 0; i < N; i++) begin
            bit rise;
            rise = s[i] && !m_sd[i];
            if (rise && m_pend[i]) m_missed[i] = 1;
            else if (w && a == 6'd5 && wd[i]) m_missed[i] = 0;
            if (rise || (w && a == 6'd3 && wd[i])) m_pend[i] = 1;
            else if (w && a == 6'd0 && wd[i]) m_pend[i] = 0;
            if (w && a == 6'd1) m_en[i] = wd[i];
            m_sd[i] = s[i];
            m_sh2[i] = m_sh1[i];
            m_sh1[i] = src[i];
        end
        if (w && a == 6'd6) m_gie = wd[0];
    endtask

    task automatic step(input logic [2:0] src, input bit me, input bit we,
                        input logic [5:0] a, input logic [7:0] wd);
        src_in = src; mod_en = me; wr_en = we; addr = a; wdata = wd;
        @(posedge clk);
        model_edge(src, me, we, a, wd);
        #1;
        chk("irq_out", 8'(irq_out), 8'(m_irq));
        chk("rdata", rdata, m_rdata);
    endtask

    task automatic idle(input logic [2:0] src);
        step(src, 0, 0, 6'd0, 8'h00);
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        step(3'b000, 1, 1, a, d);
    endtask

    task automatic rd(input string tag, input logic [5:0] a,
                      input logic [7:0] exp);
        step(src_in, 1, 0, a, 8'h00);
        chk(tag, rdata, exp);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_irq", 8'(irq_out), 8'h00);
        for (int a = 0; a < 7; a++) rd("rst_reg", 6'(a), 8'h00);

        wr(6'd1, 8'h07);
        wr(6'd6, 8'h01);
        step(3'b010, 0, 0, 6'd0, 8'h00);
        idle(3'b000);
        chk("irq_lat", 8'(irq_out), 8'h01);
        rd("pend_02", 6'd0, 8'h02);
        rd("id_81", 6'd4, 8'h81);
        wr(6'd0, 8'h02);
        idle(3'b000);
        chk("irq_fall", 8'(irq_out), 8'h00);

        step(3'b101, 0, 0, 6'd0, 8'h00);
        idle(3'b000);
        rd("pend_05", 6'd0, 8'h05);
        rd("id_80", 6'd4, 8'h80);
        wr(6'd0, 8'h01);
        rd("id_82", 6'd4, 8'h82);
        wr(6'd0, 8'h04);

        step(3'b001, 0, 0, 6'd0, 8'h00);
        idle(3'b000);
        step(3'b001, 0, 0, 6'd0, 8'h00);
        idle(3'b000);
        rd("missed_01", 6'd5, 8'h01);
        wr(6'd5, 8'h01);
        step(3'b001, 1, 1, 6'd0, 8'h01);
        idle(3'b000);
        rd("pend_keep", 6'd0, 8'h01);
        rd("missed_w1c", 6'd5, 8'h01);
        wr(6'd0, 8'h07);
        wr(6'd5, 8'h07);

        wr(6'd1, 8'h00);
        wr(6'd3, 8'h04);
        rd("pend_frc", 6'd0, 8'h04);
        chk("irq_mask", 8'(irq_out), 8'h00);
        wr(6'd1, 8'h04);
        idle(3'b000);
        chk("irq_en", 8'(irq_out), 8'h01);
        wr(6'd6, 8'h00);
        idle(3'b000);
        chk("irq_gie", 8'(irq_out), 8'h00);

        wr(6'd6, 8'h01);
        wr(6'd1, 8'h07);
        wr(6'd3, 8'h07);
        idle(3'b100);
        idle(3'b100);
        chk("pre_rst", 8'(irq_out), 8'h01);
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_irq2", 8'(irq_out), 8'h00);
        chk("rst_rd2", rdata, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        rd("pend_pre", 6'd0, 8'h00);
        for (int k = 0; k < 3; k++) idle(3'b100);
        rd("pend_lvl", 6'd0, 8'h04);
        rd("en_rst", 6'd1, 8'h00);
        rd("ctrl_rst", 6'd6, 8'h00);

        for (int n = 0; n < 400; n++) begin
            logic [5:0] a;
            a = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                            : 6'($urandom_range(0, 7));
            step(3'($urandom), 1'($urandom), 1'($urandom), a,
                 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/d_ip_irq_ctrl.md
# d_ip_irq_ctrl

Interrupt aggregator that sits directly downstream of `d_ip_timer`. It takes the timer's `overflow_int`, `comp_0_match_int` and `comp_1_match_int` lines, plus any other source, and turns them into a single CPU interrupt. Each source has a rising-edge detector, a sticky pending bit, an enable mask and a missed-event flag. The block uses the same 6-bit address / 8-bit data register bus as the timer, so both share one `mod_en`-decoded bus segment.

## Interface
Parameters:
- `N_SRC`, default 3: number of interrupt sources, legal range 1–8.
  - Bit 0 = overflow, bit 1 = compare 0 match, bit 2 = compare 1 match.

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `addr`  in  6: register address.
- `wr_en`  in  1: 1 = write, 0 = read; qualified by `mod_en`.
- `mod_en`  in  1: block select; bus access happens only when 1.
- `wdata`  in  8: write data.
- `rdata`  out  8: registered read data.
- `src_in`  in  N_SRC: interrupt source lines; these are levels or pulses of at least one `clk` cycle.
- `irq_out`  out  1: registered, level-high combined interrupt.

## Operation
Register map. Unlisted addresses read 0x00 and ignore writes. Bits at or above `N_SRC` read 0 in every register.
- 0x00 PEND (R/W1C): sticky pending bits. Writing 1 clears the bit; writing 0 has no effect.
- 0x01 ENABLE (RW): per-source mask; reset value 0x00.
- 0x02 RAW (RO): `src_in` as seen after the optional synchronizer.
- 0x03 FORCE (WO, reads 0x00): writing 1 to a bit sets the matching PEND bit.
- 0x04 ID (RO):
  - bit7 = 1 when any bit of PEND & ENABLE is set;
  - [2:0] = index of the lowest-numbered bit of PEND & ENABLE;
  - when bit7 = 0 the whole register reads 0x00.
- 0x05 MISSED (R/W1C): set when a source edge arrives while its PEND bit is already 1.
- 0x06 CTRL (RW): bit0 = GIE (global interrupt enable), reset value 0; all other bits read 0.

Edge detection:
- `s` is the (optionally synchronized) source value; `s_d` is `s` delayed by one flop.
- `rise = s & ~s_d`.
- `s_d` resets to 0. A source that is already high when reset is released therefore produces one edge.

PEND update, per bit, evaluated in each cycle:
- Set term: `rise` OR a FORCE write with a 1 in that bit.
- Clear term: a PEND write with a 1 in that bit.
- If the set term is active, the bit becomes 1 (set wins over a simultaneous W1C).
- Otherwise, if the clear term is active, the bit becomes 0.
- Otherwise the bit holds.

MISSED update, per bit:
- Set when `rise` and the old PEND bit was 1, even if a W1C of that bit happens in the same cycle.
- Cleared by W1C. Set wins over a simultaneous clear.

Output:
- `irq_out` is the next-cycle value of `GIE & |(PEND & ENABLE)`, computed from the updated register values.
- Masked pending bits still latch, so enabling a source later raises `irq_out` at once if its PEND bit is set.

## Timing
- Reset values: `rdata` = 0x00, `irq_out` = 0, all registers = 0, `s_d` = 0.
- Write: takes effect at the `clk` edge where `mod_en & wr_en` = 1.
- Read:
  - `rdata` loads the addressed register at the edge where `mod_en & ~wr_en` = 1, so data is valid one cycle after the access.
  - `rdata` holds its value at all other times.
  - A read returns register contents from before that edge.
- Latency, `IRQ_SYNC_EN` off:
  - `src_in` rises before edge k;
  - the PEND bit is 1 after edge k;
  - `irq_out` is 1 after edge k+1.
- Latency, `IRQ_SYNC_EN` on: 2 cycles more than above.
- W1C of the last enabled pending bit at edge k: `irq_out` falls after edge k+1.
- An ID read does not clear anything; acknowledgement is always a PEND W1C.
- A level held high generates exactly one edge.
- Asserting `rst` at any point clears all state at once, including any access in flight.

## Configuration
- `D_IP_IRQ_SYNC_EN` defined:
  - a two-flop synchronizer sits on each `src_in` bit before edge detection;
  - RAW shows the synchronized value;
  - latency grows by 2 cycles;
  - intended for asynchronous sources.
- `D_IP_IRQ_SYNC_EN` undefined:
  - `src_in` feeds the edge detector directly;
  - all sources must be synchronous to `clk`.

## Test plan
- Reset, then read 0x00–0x06 -> all return 0x00; `irq_out` = 0.
- ENABLE = 0x07, GIE = 1, one-cycle pulse on `src_in[1]` -> PEND = 0x02; ID = 0x81; `irq_out` high 2 cycles after the pulse; W1C 0x02 to PEND -> `irq_out` low 2 cycles later.
- `src_in[0]` and `src_in[2]` pulse together -> PEND = 0x05, ID = 0x80; W1C 0x01 -> ID = 0x82.
- PEND[0] set, second `src_in[0]` pulse -> MISSED = 0x01; W1C of PEND bit 0 in the same cycle as a new edge -> PEND[0] stays 1 and MISSED[0] = 1.
- ENABLE = 0x00, FORCE = 0x04 -> PEND = 0x04, `irq_out` = 0; then ENABLE = 0x04 -> `irq_out` = 1; then GIE = 0 -> `irq_out` = 0.
- `rst` pulsed while PEND = 0x07 and `irq_out` = 1 -> every register reads 0x00 and `irq_out` = 0 immediately; a `src_in` held high through reset gives PEND = 1 for that bit after release.
